// File: rtl/regfile_scoreboard.sv
// Register file with two write-first bypassed read ports, one write port and a per-register
// pending-write scoreboard for RAW / overflow issue stalls. Optional: REGFILE_ZERO_REG_EN.
module regfile_scoreboard #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic              iss_src1_en,
    input  logic              iss_src2_en,
    input  logic [ADDR_W-1:0] iss_src1,
    input  logic [ADDR_W-1:0] iss_src2,
    input  logic              iss_dst_en,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_stall,
    output logic              pend_any,
    output logic              sb_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
`ifdef REGFILE_ZERO_REG_EN
    localparam logic ZERO_EN = 1'b1;
`else
    localparam logic ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0] regs_r      [DEPTH];
    logic [PEND_W-1:0] pend_r      [DEPTH];
    logic [PEND_W-1:0] pend_next_s [DEPTH];
    logic              inc_s       [DEPTH];
    logic              dec_s       [DEPTH];
    logic              sb_err_r;
    logic              retire1_s, retire2_s, haz1_s, haz2_s, ovf_s, stall_s;
    logic              accept_s, err_set_s, any_s;

    // Read port 1: hardwired zero, write-first bypass, or storage.
    always_comb begin
        if (ZERO_EN && rd1_addr == '0) begin
            rd1_data = '0;
        end else if (wr_en && wr_addr == rd1_addr) begin
            rd1_data = wr_data;
        end else begin
            rd1_data = regs_r[rd1_addr];
        end
    end

    // Read port 2: hardwired zero, write-first bypass, or storage.
    always_comb begin
        if (ZERO_EN && rd2_addr == '0) begin
            rd2_data = '0;
        end else if (wr_en && wr_addr == rd2_addr) begin
            rd2_data = wr_data;
        end else begin
            rd2_data = regs_r[rd2_addr];
        end
    end

    // Hazard detection; a final retire this cycle feeds the source through the bypass.
    always_comb begin
        retire1_s = wr_en && (wr_addr == iss_src1) && (pend_r[iss_src1] == PEND_ONE);
        retire2_s = wr_en && (wr_addr == iss_src2) && (pend_r[iss_src2] == PEND_ONE);
        haz1_s    = iss_src1_en && (pend_r[iss_src1] != '0) && !retire1_s;
        haz2_s    = iss_src2_en && (pend_r[iss_src2] != '0) && !retire2_s;
        ovf_s     = iss_dst_en && (pend_r[iss_dst] == PEND_MAX) && !(wr_en && wr_addr == iss_dst);
        if (iss_valid) begin
            stall_s = haz1_s || haz2_s || ovf_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign iss_stall = stall_s;

    // Next pending counts; simultaneous issue and retire of one register cancel out.
    always_comb begin
        accept_s  = iss_valid && !stall_s;
        err_set_s = 1'b0;
        any_s     = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            inc_s[r] = accept_s && iss_dst_en && (iss_dst == ADDR_W'(r)) && !(ZERO_EN && r == 0);
            dec_s[r] = wr_en && (wr_addr == ADDR_W'(r));
            pend_next_s[r] = pend_r[r];
            if (inc_s[r] && !dec_s[r]) begin
                pend_next_s[r] = pend_r[r] + PEND_ONE;
            end else if (dec_s[r] && !inc_s[r]) begin
                if (pend_r[r] != '0) begin
                    pend_next_s[r] = pend_r[r] - PEND_ONE;
                end else if (!(ZERO_EN && r == 0)) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_next_s[r] = '0;
                end
            end else begin
                pend_next_s[r] = pend_r[r];
            end
            any_s = any_s || (pend_r[r] != '0);
        end
    end

    assign pend_any = any_s;
    assign sb_err   = sb_err_r;

    // Storage, counters and sticky error; reset wins over any concurrent write or issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
                pend_r[i] <= '0;
            end
            sb_err_r <= 1'b0;
        end else begin
            if (wr_en && !(ZERO_EN && wr_addr == '0)) begin
                regs_r[wr_addr] <= wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                pend_r[i] <= pend_next_s[i];
            end
            if (err_set_s) begin
                sb_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with an integrated write-pending scoreboard for the pipelined CPU. It sits between decode and the ID/EXE stage register and is written by writeback. It provides two bypassed read ports and one synchronous write port. It also tracks in-flight destination writes per register, so decode can stall on RAW hazards and destination-count overflow. It replaces the fixed 4x8, level-sensitive main register file.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 2, register address width; depth = 2**ADDR_W
- PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**PEND_W-1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd1_addr  in  ADDR_W  read port 1 address
- rd1_data  out  DATA_W  read port 1 data (combinational)
- rd2_addr  in  ADDR_W  read port 2 address
- rd2_data  out  DATA_W  read port 2 data (combinational)
- wr_en  in  1  writeback strobe; writes the register and retires one pending write
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- iss_valid  in  1  decode presents an instruction for issue
- iss_src1_en / iss_src2_en  in  1 each  instruction reads src1/src2
- iss_src1 / iss_src2  in  ADDR_W each  source registers
- iss_dst_en  in  1  instruction writes a destination
- iss_dst  in  ADDR_W  destination register
- iss_stall  out  1  issue blocked this cycle (combinational)
- pend_any  out  1  at least one pending counter non-zero (registered state, combinational OR)
- sb_err  out  1  sticky: a retire hit a zero counter

## Operation
- Storage: 2**ADDR_W x DATA_W flops. Write happens on the rising edge when wr_en=1 and not rst.
- Read bypass (write-first): rdN_data = wr_data if wr_en && wr_addr==rdN_addr; otherwise the stored value.
- Scoreboard: one PEND_W-bit counter per register.
- Issue accepted = iss_valid && !iss_stall. Accepted with iss_dst_en increments pend[iss_dst].
- Retire: wr_en decrements pend[wr_addr].
- Same register incremented and retired in one cycle: counter unchanged.
- Retire with pend==0 and no same-cycle increment of that register: counter stays 0 and sb_err sets.
- retiring(r) = wr_en && wr_addr==r && pend[r]==1.
- src hazard for srcN = iss_srcN_en && pend[iss_srcN]!=0 && !retiring(iss_srcN). A final retire satisfies the read through the bypass.
- dst overflow = iss_dst_en && pend[iss_dst]==max && !(wr_en && wr_addr==iss_dst).
- iss_stall = iss_valid && (src1 hazard || src2 hazard || dst overflow). iss_stall is 0 when iss_valid=0.
- Writes are not gated by the scoreboard. Writeback is always accepted.

## Timing
- Reset (rst=1 at an edge):
  - All registers and counters go to 0; sb_err goes to 0.
  - Concurrent wr_en and issue are ignored.
  - Outputs after reset: rd1_data=rd2_data=0 unless bypassing, iss_stall=0, pend_any=0, sb_err=0.
  - Reset mid-operation discards all in-flight tracking. Writebacks retiring after reset set sb_err; the pipeline is flushed together with rst.
- Read latency 0 (combinational). A write is visible through the bypass in the same cycle and from storage in the next cycle.
- Counter updates take effect at the edge after the accept/retire cycle. iss_stall reflects the new counts in the following cycle.
- Counters never wrap: overflow is prevented by stall, underflow by clamping.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Register 0 reads 0 and writes to it are discarded; the bypass is also suppressed for address 0.
  - pend[0] never increments, so a src of 0 never stalls.
  - A retire to 0 never sets sb_err.
- Undefined: register 0 is an ordinary register, identical to the others.

## Test plan
- Reset, then read all addresses -> 0. Write 0xA5 to r2 with rd1_addr=2 in the same cycle -> rd1_data=0xA5 that cycle and the next.
- Issue dst=r1, next cycle issue src1=r1 -> iss_stall=1. Retire r1 (wr_en, 0x3C) -> iss_stall=0 that cycle and rd1_data=0x3C via bypass; pend_any=0 afterwards.
- PEND_W=2: issue three writes to r3 -> fourth issue to dst r3 stalls. The same issue with a concurrent retire of r3 is accepted, and the counter stays at 3.
- Same-cycle issue dst=r2 and retire r2 with pend[r2]=1 -> pend[r2] stays 1 and a subsequent src=r2 stalls.
- Retire r0 with an empty scoreboard -> sb_err=1 and remains 1 until rst; with REGFILE_ZERO_REG_EN, sb_err stays 0 and r0 reads 0 after writing 0xFF.
- Assert rst with pend[1]=2 -> next cycle pend_any=0, iss_stall=0, sb_err=0, and all registers read 0.
